// File: rtl/ebi_bridge_pkg.sv
// Shared types and constants for the external-bus to channel-bus bridge.
package ebi_bridge_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    localparam int          WIN_W             = 4;
    localparam logic [15:0] TIMEOUT_RDATA_DEF = 16'hDEAD;
endpackage

// File: rtl/ebi_bridge_nch_if.sv
// Channel register bus: shared address/write data, per-channel strobes and acks.
interface ebi_bridge_nch_if #(
    parameter int NUM_CH = 4,
    parameter int AW     = 8,
    parameter int DW     = 16
);
    logic [AW-1:0]        ch_addr;
    logic [DW-1:0]        ch_wdata;
    logic [NUM_CH-1:0]    ch_we;
    logic [NUM_CH-1:0]    ch_oe;
    logic [NUM_CH*DW-1:0] ch_rdata;
    logic [NUM_CH-1:0]    ch_ack;

    modport master (output ch_addr, ch_wdata, ch_we, ch_oe, input ch_rdata, ch_ack);
    modport slave  (input ch_addr, ch_wdata, ch_we, ch_oe, output ch_rdata, ch_ack);
endinterface

// File: rtl/ebi_strobe_sync.sv
// Multi-flop synchroniser for the async bus strobes plus falling-edge detect.
module ebi_strobe_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic oe_n,
    input  logic we_n,
    output logic cs_n_s,
    output logic oe_n_s,
    output logic we_n_s,
    output logic rd_edge,
    output logic wr_edge
);
    logic [SYNC_STAGES-1:0] cs_sh, oe_sh, we_sh;
    logic                   oe_prev, we_prev;

    // Idle level is high, so reset fills the chains with ones (no false edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sh   <= '1;
            oe_sh   <= '1;
            we_sh   <= '1;
            oe_prev <= 1'b1;
            we_prev <= 1'b1;
        end else begin
            cs_sh   <= {cs_sh[SYNC_STAGES-2:0], cs_n};
            oe_sh   <= {oe_sh[SYNC_STAGES-2:0], oe_n};
            we_sh   <= {we_sh[SYNC_STAGES-2:0], we_n};
            oe_prev <= oe_sh[SYNC_STAGES-1];
            we_prev <= we_sh[SYNC_STAGES-1];
        end
    end

    assign cs_n_s  = cs_sh[SYNC_STAGES-1];
    assign oe_n_s  = oe_sh[SYNC_STAGES-1];
    assign we_n_s  = we_sh[SYNC_STAGES-1];
    assign rd_edge = oe_prev & ~oe_n_s & ~cs_n_s;
    assign wr_edge = we_prev & ~we_n_s & ~cs_n_s;
endmodule

// File: rtl/ebi_bridge_nch.sv
// External async CPU bus to NUM_CH channel register buses, with wait-state
// generation and a bus timeout.
module ebi_bridge_nch
    import ebi_bridge_pkg::*;
#(
    parameter int                   P_BUS_ADDR_WIDTH = 12,
    parameter int                   P_BUS_DATA_WIDTH = 16,
    parameter int                   CBUS_ADDR_WIDTH  = 8,
    parameter int                   CBUS_DATA_WIDTH  = 16,
    parameter int                   NUM_CH           = 4,
    parameter logic [31:0]          BASE_ADDR_LIST   = 32'h0000_3210,
    parameter int                   SYNC_STAGES      = 3,
    parameter int                   TIMEOUT_CYC      = 255,
    parameter logic [CBUS_DATA_WIDTH-1:0] TIMEOUT_RDATA = TIMEOUT_RDATA_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [P_BUS_ADDR_WIDTH-1:0] lbus_addr,
    inout  wire  [P_BUS_DATA_WIDTH-1:0] lbus_data,
    input  logic                        lbus_cs_n,
    input  logic                        lbus_oe_n,
    input  logic                        lbus_we_n,
    output logic                        lbus_wait_n,
    ebi_bridge_nch_if.master            ch,
    output logic                        err_timeout,
    input  logic                        err_clr
);
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic cs_s, oe_s, we_s, rd_edge, wr_edge;

    ebi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (lbus_cs_n),
        .oe_n    (lbus_oe_n),
        .we_n    (lbus_we_n),
        .cs_n_s  (cs_s),
        .oe_n_s  (oe_s),
        .we_n_s  (we_s),
        .rd_edge (rd_edge),
        .wr_edge (wr_edge)
    );

    logic [WIN_W-1:0] win;
    logic             hit;
    logic [SW-1:0]    hit_idx;

    assign win = lbus_addr[CBUS_ADDR_WIDTH +: WIN_W];

    // Scan high to low so the lowest matching channel wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (win == BASE_ADDR_LIST[4*i +: WIN_W]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    state_t                      state;
    logic                        is_rd;
    logic [SW-1:0]               sel;
    logic [15:0]                 timer;
    logic [P_BUS_DATA_WIDTH-1:0] rd_latch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            is_rd       <= 1'b0;
            sel         <= '0;
            timer       <= '0;
            rd_latch    <= '0;
            lbus_wait_n <= 1'b1;
            err_timeout <= 1'b0;
            ch.ch_addr  <= '0;
            ch.ch_wdata <= '0;
            ch.ch_we    <= '0;
            ch.ch_oe    <= '0;
        end else begin
            ch.ch_we <= '0;
            ch.ch_oe <= '0;
            if (err_clr) err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Read edge takes priority when both strobes fall together.
                    if (rd_edge | wr_edge) begin
                        is_rd       <= rd_edge;
                        lbus_wait_n <= 1'b0;
                        state       <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (hit) begin
                        sel        <= hit_idx;
                        ch.ch_addr <= lbus_addr[CBUS_ADDR_WIDTH-1:0];
                        if (!is_rd) ch.ch_wdata <= lbus_data;
                        state      <= ST_REQ;
                    end else begin
                        rd_latch    <= '0;
                        lbus_wait_n <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_REQ: begin
                    if (is_rd) ch.ch_oe[sel] <= 1'b1;
                    else       ch.ch_we[sel] <= 1'b1;
                    timer <= '0;
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ch.ch_ack[sel]) begin
                        if (is_rd) rd_latch <= ch.ch_rdata[int'(sel)*CBUS_DATA_WIDTH +: CBUS_DATA_WIDTH];
                        lbus_wait_n <= 1'b1;
                        state       <= ST_DONE;
                    end else if (timer == 16'(TIMEOUT_CYC)) begin
                        rd_latch    <= TIMEOUT_RDATA;
                        err_timeout <= 1'b1;
                        lbus_wait_n <= 1'b1;
                        state       <= ST_DONE;
                    end else if (timer != 16'hFFFF) begin
                        timer <= timer + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (cs_s | (oe_s & we_s)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Drive enable follows the raw pins so the bus turns around without sync delay.
    assign lbus_data = (lbus_oe_n | lbus_cs_n) ? {P_BUS_DATA_WIDTH{1'bz}} : rd_latch;
endmodule

// File: tb/tb_ebi_bridge_nch.sv
// Scoreboard bench for ebi_bridge_nch: CPU bus tasks, channel responder, strobe monitor.
module tb_ebi_bridge_nch;
    localparam int SYNC = 3;
    localparam int TO   = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] lbus_addr = '0;
    logic        lbus_cs_n = 1'b1, lbus_oe_n = 1'b1, lbus_we_n = 1'b1;
    logic        lbus_wait_n, err_timeout;
    logic        err_clr = 1'b0;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_wd = '0;
    wire  [15:0] lbus_data;

    assign lbus_data = tb_drv ? tb_wd : 16'hzzzz;

    ebi_bridge_nch_if #(.NUM_CH(4), .AW(8), .DW(16)) cb ();

    ebi_bridge_nch #(
        .NUM_CH         (4),
        .BASE_ADDR_LIST (32'h0000_3710),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYC    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lbus_addr   (lbus_addr),
        .lbus_data   (lbus_data),
        .lbus_cs_n   (lbus_cs_n),
        .lbus_oe_n   (lbus_oe_n),
        .lbus_we_n   (lbus_we_n),
        .lbus_wait_n (lbus_wait_n),
        .ch          (cb.master),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_run = 0, n_fail = 0, cyc = 0, strobe_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  we;
        logic [3:0]  oe;
        logic [7:0]  addr;
        logic [15:0] wd;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: every strobe cycle must match the next expected request.
    initial begin
        forever begin
            @(negedge clk);
            if (|cb.ch_we || |cb.ch_oe) begin
                strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_strobe", {cb.ch_we, cb.ch_oe}, 8'h00);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_we", cb.ch_we, e.we);
                    chk("sb_oe", cb.ch_oe, e.oe);
                    chk("sb_addr", cb.ch_addr, e.addr);
                    if (|e.we) chk("sb_wdata", cb.ch_wdata, e.wd);
                end
            end
        end
    end

    // Responder: acks the strobed channel after ack_dly cycles.
    bit          ack_en = 1'b1, spur_en = 1'b0;
    int          ack_dly = 1;
    logic [15:0] ack_data = '0;
    initial begin
        cb.ch_ack   = '0;
        cb.ch_rdata = 64'h3333_2222_1111_0000;
        forever begin
            @(negedge clk);
            if ((|cb.ch_we || |cb.ch_oe) && ack_en) begin
                int c;
                c = 0;
                for (int i = 3; i >= 0; i--) if (cb.ch_we[i] | cb.ch_oe[i]) c = i;
                if (spur_en) cb.ch_ack = 4'b1000;
                for (int k = 1; k < ack_dly; k++) begin
                    @(negedge clk);
                    cb.ch_ack = '0;
                end
                chk("rsp_wait_lo_before_ack", lbus_wait_n, 1'b0);
                cb.ch_rdata[c*16 +: 16] = ack_data;
                cb.ch_ack[c] = 1'b1;
                @(negedge clk);
                cb.ch_ack = '0;
                chk("rsp_wait_hi_after_ack", lbus_wait_n, 1'b1);
            end
        end
    end

    task automatic cpu_access(input string tag, input bit rd, input bit both,
                              input logic [11:0] a, input logic [15:0] wd,
                              input bit hit, input logic [15:0] exp_rd, output int done_cyc);
        int n;
        @(negedge clk);
        lbus_addr = a;
        lbus_cs_n = 1'b0;
        if (!rd) begin tb_drv = 1'b1; tb_wd = wd; end
        @(negedge clk);
        lbus_oe_n = rd ? 1'b0 : 1'b1;
        lbus_we_n = (rd && !both) ? 1'b1 : 1'b0;
        repeat (SYNC+3) @(negedge clk);
        chk({tag, "_wait_early"}, lbus_wait_n, hit ? 1'b0 : 1'b1);
        n = 0;
        while (!lbus_wait_n && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait_bound"}, lbus_wait_n, 1'b1);
        done_cyc = cyc;
        if (rd) chk({tag, "_rdata"}, lbus_data, exp_rd);
        @(negedge clk);
        lbus_oe_n = 1'b1;
        lbus_we_n = 1'b1;
        lbus_cs_n = 1'b1;
        tb_drv    = 1'b0;
        repeat (SYNC+3) @(negedge clk);
    endtask

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        chk("rst_wait_n", lbus_wait_n, 1'b1);
        chk("rst_we", cb.ch_we, 4'h0);
        chk("rst_oe", cb.ch_oe, 4'h0);
        chk("rst_addr", cb.ch_addr, 8'h00);
        chk("rst_wdata", cb.ch_wdata, 16'h0000);
        chk("rst_err", err_timeout, 1'b0);
        rst = 1'b0;
        repeat (SYNC+2) @(negedge clk);

        ack_dly = 1;
        exp_q.push_back('{we: 4'b0100, oe: 4'b0000, addr: 8'hA5, wd: 16'h1234});
        cpu_access("wr_ch2", 1'b0, 1'b0, 12'h7A5, 16'h1234, 1'b1, 16'h0, dc);

        ack_dly = 5; ack_data = 16'hBEEF;
        exp_q.push_back('{we: 4'b0000, oe: 4'b0001, addr: 8'h12, wd: 16'h0});
        cpu_access("rd_ch0", 1'b1, 1'b0, 12'h012, 16'h0, 1'b1, 16'hBEEF, dc);

        cpu_access("rd_miss", 1'b1, 1'b0, 12'hF00, 16'h0, 1'b0, 16'h0000, dc);
        chk("miss_err", err_timeout, 1'b0);

        ack_en = 1'b0;
        exp_q.push_back('{we: 4'b0000, oe: 4'b0010, addr: 8'h55, wd: 16'h0});
        cpu_access("rd_to", 1'b1, 1'b0, 12'h155, 16'h0, 1'b1, 16'hDEAD, dc);
        chk("to_cycles", dc - strobe_cyc, TO + 1);
        chk("to_err_set", err_timeout, 1'b1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("to_err_clr", err_timeout, 1'b0);

        ack_en = 1'b1; ack_dly = 3; ack_data = 16'h600D; spur_en = 1'b1;
        exp_q.push_back('{we: 4'b0000, oe: 4'b0001, addr: 8'h33, wd: 16'h0});
        cpu_access("rd_both", 1'b1, 1'b1, 12'h033, 16'h0, 1'b1, 16'h600D, dc);
        spur_en = 1'b0;

        // Reset while waiting for an ack that never comes.
        ack_en = 1'b0;
        exp_q.push_back('{we: 4'b0000, oe: 4'b0001, addr: 8'h44, wd: 16'h0});
        @(negedge clk); lbus_addr = 12'h044; lbus_cs_n = 1'b0;
        @(negedge clk); lbus_oe_n = 1'b0;
        repeat (SYNC+5) @(negedge clk);
        chk("mid_wait_lo", lbus_wait_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wait_n", lbus_wait_n, 1'b1);
        chk("mid_rst_oe", cb.ch_oe, 4'h0);
        chk("mid_rst_addr", cb.ch_addr, 8'h00);
        lbus_oe_n = 1'b1; lbus_cs_n = 1'b1;
        repeat (SYNC+2) @(negedge clk);
        rst = 1'b0;
        cb.ch_ack = 4'b0001;
        @(negedge clk); cb.ch_ack = '0;
        @(negedge clk);
        chk("post_rst_idle_wait", lbus_wait_n, 1'b1);
        ack_en = 1'b1; ack_dly = 2;
        exp_q.push_back('{we: 4'b0001, oe: 4'b0000, addr: 8'hC3, wd: 16'h55AA});
        cpu_access("wr_after_rst", 1'b0, 1'b0, 12'h0C3, 16'h55AA, 1'b1, 16'h0, dc);

        repeat (5) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
